// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine: mode encodings, default
// B3/S23 rule masks and the row/column to flat-cell index mapping.
package life_pkg;

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_PROGRAM = 2'b01,
        ST_RUN     = 2'b10,
        ST_PAUSE   = 2'b11
    } game_state_t;

    localparam logic [8:0] RULE_B3  = 9'b000001000;
    localparam logic [8:0] RULE_S23 = 9'b000001100;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational successor grid: counts the eight neighbours of every cell and
// applies the birth/survive masks. Neighbour wiring is resolved at elaboration.
module life_next_gen
    import life_pkg::*;
#(
    parameter int         ROWS    = 7,
    parameter int         COLS    = 7,
    parameter int         WRAP    = 1,
    parameter logic [8:0] BIRTH   = RULE_B3,
    parameter logic [8:0] SURVIVE = RULE_S23
)(
    input  logic [ROWS*COLS-1:0] grid,
    output logic [ROWS*COLS-1:0] next_grid
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int SELF = cell_idx(r, c, COLS);

            logic [8:0] nbr;
            logic [3:0] count;

            // Slot 4 of the 3x3 window is the cell itself and never counts.
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                localparam int DR = k / 3 - 1;
                localparam int DC = k % 3 - 1;
                localparam int RR = (WRAP != 0) ? (r + DR + ROWS) % ROWS : r + DR;
                localparam int CC = (WRAP != 0) ? (c + DC + COLS) % COLS : c + DC;

                if (k == 4 || RR < 0 || RR >= ROWS || CC < 0 || CC >= COLS) begin : g_dead
                    assign nbr[k] = 1'b0;
                end else begin : g_live
                    localparam int IDX = cell_idx(RR, CC, COLS);
                    assign nbr[k] = grid[IDX];
                end
            end

            always_comb begin
                count = '0;
                for (int j = 0; j < 9; j++) begin
                    count = count + {3'b000, nbr[j]};
                end
            end

            assign next_grid[SELF] = grid[SELF] ? SURVIVE[count] : BIRTH[count];
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life core: mode FSM, programming cursor, grid register, generation
// timer and counter, plus stable/extinct flags around a combinational stepper.
module life_engine
    import life_pkg::*;
#(
    parameter int         ROWS       = 7,
    parameter int         COLS       = 7,
    parameter int         WRAP       = 1,
    parameter logic [8:0] BIRTH      = RULE_B3,
    parameter logic [8:0] SURVIVE    = RULE_S23,
    parameter int         PERIOD     = 4,
    parameter int         GEN_W      = 16,
    parameter int         AUTO_PAUSE = 1
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stop,
    input  logic                         prgm,
    input  logic                         pp,
    input  logic                         step,
    input  logic                         btn0,
    input  logic                         btn1,
    output logic [1:0]                   game_state,
    output logic [ROWS*COLS-1:0]         grid,
    output logic [$clog2(ROWS*COLS)-1:0] cursor,
    output logic [GEN_W-1:0]             gen_count,
    output logic                         stable,
    output logic                         extinct
);

    localparam int CELLS  = ROWS * COLS;
    localparam int CUR_W  = $clog2(CELLS);
    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CUR_W-1:0]  CUR_LAST  = CUR_W'(CELLS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);

    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    game_state_t       state_q;
    logic [CELLS-1:0]  grid_q;
    logic [CELLS-1:0]  next_grid;
    logic [CUR_W-1:0]  cursor_q;
    logic [GEN_W-1:0]  gen_q;
    logic              stable_q;
    logic [TICK_W-1:0] tick_q;

    logic pause_req;
    logic run_update;
    logic step_update;
    logic do_update;
    logic grid_same;
    logic next_empty;

    life_next_gen #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WRAP    (WRAP),
        .BIRTH   (BIRTH),
        .SURVIVE (SURVIVE)
    ) u_next_gen (
        .grid      (grid_q),
        .next_grid (next_grid)
    );

    // prgm outranks pp even in states where prgm itself has no effect.
    assign pause_req   = pp && !prgm;
    assign run_update  = (state_q == ST_RUN) && !pause_req && (tick_q == TICK_LAST);
    assign step_update = (state_q == ST_PAUSE) && !prgm && !pp && step;
    assign do_update   = !stop && (run_update || step_update);
    assign grid_same   = (next_grid == grid_q);
    assign next_empty  = (next_grid == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOP;
            grid_q   <= '0;
            cursor_q <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            tick_q   <= '0;
        end else if (stop) begin
            state_q  <= ST_STOP;
            grid_q   <= '0;
            cursor_q <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            tick_q   <= '0;
        end else begin
            if (do_update) begin
                grid_q   <= next_grid;
                gen_q    <= sat_inc(gen_q);
                stable_q <= grid_same;
            end

            case (state_q)
                ST_STOP: begin
                    if (prgm) state_q <= ST_PROGRAM;
                end

                ST_PROGRAM: begin
                    // Toggle uses the pre-advance cursor when both buttons coincide.
                    if (btn1) grid_q[cursor_q] <= ~grid_q[cursor_q];
                    if (btn0) cursor_q <= (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
                    if (pause_req) begin
                        state_q  <= ST_RUN;
                        tick_q   <= '0;
                        stable_q <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (pause_req) begin
                        state_q <= ST_PAUSE;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (AUTO_PAUSE != 0 && (grid_same || next_empty)) state_q <= ST_PAUSE;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end

                ST_PAUSE: begin
                    if (prgm) begin
                        state_q <= ST_PROGRAM;
                    end else if (pp) begin
                        state_q <= ST_RUN;
                        tick_q  <= '0;
                    end
                end

                default: state_q <= ST_STOP;
            endcase
        end
    end

    assign game_state = state_q;
    assign grid       = grid_q;
    assign cursor     = cursor_q;
    assign gen_count  = gen_q;
    assign stable     = stable_q;
    assign extinct    = ~|grid_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: two 5x5 instances (dead-edge/auto-pause/16-bit counter
// and toroidal/free-running/4-bit counter) share stimulus against a reference model.
module tb_life_engine;

    localparam int N      = 25;
    localparam int PERIOD = 4;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_STOP = 6'b100000;
    localparam logic [5:0] P_PRGM = 6'b010000;
    localparam logic [5:0] P_PP   = 6'b001000;
    localparam logic [5:0] P_STEP = 6'b000100;
    localparam logic [5:0] P_BTN0 = 6'b000010;
    localparam logic [5:0] P_BTN1 = 6'b000001;

    localparam logic [24:0] PAT_BLINK_H = 25'h0003800;  // bits 11,12,13
    localparam logic [24:0] PAT_BLINK_V = 25'h0021080;  // bits 7,12,17
    localparam logic [24:0] PAT_BLOCK   = 25'h00018C0;  // bits 6,7,11,12
    localparam logic [24:0] PAT_SINGLE  = 25'h0001000;  // bit 12
    localparam logic [24:0] PAT_GLIDER  = 25'h0001C82;  // bits 1,7,10,11,12

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stop = 1'b0, prgm = 1'b0, pp = 1'b0, step = 1'b0, btn0 = 1'b0, btn1 = 1'b0;

    logic [1:0]  gs0, gs1;
    logic [24:0] grid0, grid1;
    logic [4:0]  cur0, cur1;
    logic [15:0] gen0;
    logic [3:0]  gen1;
    logic        stb0, stb1, ext0, ext1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    life_engine #(.ROWS(5), .COLS(5), .WRAP(0), .PERIOD(PERIOD), .GEN_W(16), .AUTO_PAUSE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
        .btn0(btn0), .btn1(btn1), .game_state(gs0), .grid(grid0), .cursor(cur0),
        .gen_count(gen0), .stable(stb0), .extinct(ext0)
    );

    life_engine #(.ROWS(5), .COLS(5), .WRAP(1), .PERIOD(PERIOD), .GEN_W(4), .AUTO_PAUSE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
        .btn0(btn0), .btn1(btn1), .game_state(gs1), .grid(grid1), .cursor(cur1),
        .gen_count(gen1), .stable(stb1), .extinct(ext1)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [24:0] grid;
        logic [4:0]  cur;
        logic [15:0] gen;
        logic        stable;
        logic        extinct;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t e0;
        obs_t e1;
    } sb_t;

    typedef struct {
        int          st;
        logic [24:0] grid;
        int          cur;
        int          gen;
        bit          stable;
        int          tick;
    } mstate_t;

    sb_t     sb_q[$];
    mstate_t m[2];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Plain Conway B3/S23 on a 5x5 grid, optionally toroidal.
    function automatic logic [24:0] life_step(input logic [24:0] g, input bit wrap);
        logic [24:0] nx;
        int n, rr, cc;
        nx = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 5) % 5;
                            cc = (cc + 5) % 5;
                        end
                        if (rr >= 0 && rr < 5 && cc >= 0 && cc < 5) n += int'(g[rr*5+cc]);
                    end
                end
                if (g[r*5+c]) nx[r*5+c] = (n == 2 || n == 3);
                else          nx[r*5+c] = (n == 3);
            end
        end
        return nx;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].st = 0; m[i].grid = '0; m[i].cur = 0; m[i].gen = 0; m[i].stable = 0; m[i].tick = 0;
        end
    endtask

    // Instance 0: dead edges, auto-pause, 16-bit counter. Instance 1: torus, no auto-pause, 4-bit counter.
    task automatic model_apply(input int i, input logic [5:0] p);
        mstate_t s;
        logic [24:0] nx;
        bit upd;
        int gmax;
        s = m[i];
        upd = 0;
        gmax = (i == 0) ? 65535 : 15;
        if (p[5]) begin
            s.st = 0; s.grid = '0; s.cur = 0; s.gen = 0; s.stable = 0; s.tick = 0;
        end else begin
            case (s.st)
                0: if (p[4]) s.st = 1;
                1: begin
                    if (p[0]) s.grid[s.cur] = ~s.grid[s.cur];
                    if (p[1]) s.cur = (s.cur + 1) % N;
                    if (p[3] && !p[4]) begin s.st = 2; s.tick = 0; s.stable = 0; end
                end
                2: begin
                    if (p[3] && !p[4]) s.st = 3;
                    else if (s.tick == PERIOD - 1) begin s.tick = 0; upd = 1; end
                    else s.tick++;
                end
                default: begin
                    if (p[4]) s.st = 1;
                    else if (p[3]) begin s.st = 2; s.tick = 0; end
                    else if (p[2]) upd = 1;
                end
            endcase
            if (upd) begin
                nx = life_step(s.grid, i == 1);
                s.stable = (nx == s.grid);
                s.grid = nx;
                if (s.gen < gmax) s.gen++;
                if (s.st == 2 && i == 0 && (s.stable || nx == '0)) s.st = 3;
            end
        end
        m[i] = s;
    endtask

    function automatic obs_t expect_of(input int i);
        obs_t o;
        o.st      = 2'(m[i].st);
        o.grid    = m[i].grid;
        o.cur     = 5'(m[i].cur);
        o.gen     = 16'(m[i].gen);
        o.stable  = m[i].stable;
        o.extinct = (m[i].grid == '0);
        return o;
    endfunction

    function automatic obs_t observe(input int i);
        obs_t o;
        if (i == 0) o = '{st: gs0, grid: grid0, cur: cur0, gen: gen0, stable: stb0, extinct: ext0};
        else        o = '{st: gs1, grid: grid1, cur: cur1, gen: {12'b0, gen1}, stable: stb1, extinct: ext1};
        return o;
    endfunction

    task automatic compare_obs(input int i, input obs_t exp);
        obs_t act;
        act = observe(i);
        check($sformatf("u%0d.game_state", i), 32'(act.st), 32'(exp.st));
        check($sformatf("u%0d.grid", i), 32'(act.grid), 32'(exp.grid));
        check($sformatf("u%0d.cursor", i), 32'(act.cur), 32'(exp.cur));
        check($sformatf("u%0d.gen_count", i), 32'(act.gen), 32'(exp.gen));
        check($sformatf("u%0d.stable", i), 32'(act.stable), 32'(exp.stable));
        check($sformatf("u%0d.extinct", i), 32'(act.extinct), 32'(exp.extinct));
    endtask

    // Monitor: pops every expectation whose target edge has passed.
    always @(negedge clk) begin
        sb_t t;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            t = sb_q.pop_front();
            compare_obs(0, t.e0);
            compare_obs(1, t.e1);
        end
    end

    // Called just after a rising edge; drives one cycle of pulses and returns after the consuming edge.
    task automatic tick_in(input logic [5:0] p);
        sb_t t;
        {stop, prgm, pp, step, btn0, btn1} = p;
        model_apply(0, p);
        model_apply(1, p);
        t.cyc = cyc + 1;
        t.e0  = expect_of(0);
        t.e1  = expect_of(1);
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        {stop, prgm, pp, step, btn0, btn1} = P_NONE;
    endtask

    // Assumes PROGRAM with cursor 0; visits every cell once and leaves cursor at 0.
    task automatic program_cells(input logic [24:0] pat);
        for (int idx = 0; idx < N; idx++) begin
            if (pat[idx]) tick_in(P_BTN1);
            tick_in(P_BTN0);
        end
    endtask

    function automatic logic [5:0] rand_pulse();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)  return P_STOP;
        if (r < 8)  return P_PRGM;
        if (r < 16) return P_PP;
        if (r < 24) return P_STEP;
        if (r < 50) return P_BTN0;
        if (r < 62) return P_BTN1;
        if (r < 66) return P_BTN0 | P_BTN1;
        return P_NONE;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        check("reset.game_state", 32'(gs0), 32'd0);
        check("reset.grid", 32'(grid0), 32'd0);
        check("reset.cursor", 32'(cur0), 32'd0);
        check("reset.gen_count", 32'(gen0), 32'd0);
        check("reset.stable", 32'(stb0), 32'd0);
        check("reset.extinct", 32'(ext0), 32'd1);
        check("reset.u1.grid", 32'(grid1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3) tick_in(P_NONE);
        check("idle.game_state", 32'(gs0), 32'd0);

        // Blinker
        tick_in(P_PRGM);
        program_cells(PAT_BLINK_H);
        check("blink.programmed", 32'(grid0), 32'(PAT_BLINK_H));
        tick_in(P_PP);
        repeat (3) tick_in(P_NONE);
        check("blink.no_early_update", 32'(gen0), 32'd0);
        tick_in(P_NONE);
        check("blink.gen1.grid", 32'(grid0), 32'(PAT_BLINK_V));
        check("blink.gen1.count", 32'(gen0), 32'd1);
        check("blink.gen1.u1.grid", 32'(grid1), 32'(PAT_BLINK_V));
        repeat (4) tick_in(P_NONE);
        check("blink.gen2.grid", 32'(grid0), 32'(PAT_BLINK_H));
        check("blink.gen2.count", 32'(gen0), 32'd2);
        check("blink.gen2.stable", 32'(stb0), 32'd0);
        tick_in(P_STOP);

        // Block still life
        tick_in(P_PRGM);
        program_cells(PAT_BLOCK);
        tick_in(P_PP);
        repeat (4) tick_in(P_NONE);
        check("block.autopause", 32'(gs0), 32'd3);
        check("block.stable", 32'(stb0), 32'd1);
        check("block.count", 32'(gen0), 32'd1);
        check("block.u1.running", 32'(gs1), 32'd2);
        check("block.u1.stable", 32'(stb1), 32'd1);
        tick_in(P_STOP);

        // Single cell with step
        tick_in(P_PRGM);
        program_cells(PAT_SINGLE);
        tick_in(P_PP);
        tick_in(P_PP);
        check("single.paused", 32'(gs0), 32'd3);
        tick_in(P_STEP);
        check("single.step1.grid", 32'(grid0), 32'd0);
        check("single.step1.extinct", 32'(ext0), 32'd1);
        check("single.step1.count", 32'(gen0), 32'd1);
        tick_in(P_STEP);
        check("single.step2.count", 32'(gen0), 32'd2);
        check("single.step2.state", 32'(gs0), 32'd3);
        tick_in(P_STOP);

        // Glider on torus: 20 generations return it home; 4-bit counter saturates
        tick_in(P_PRGM);
        program_cells(PAT_GLIDER);
        tick_in(P_PP);
        repeat (20 * PERIOD) tick_in(P_NONE);
        check("glider.u1.grid", 32'(grid1), 32'(PAT_GLIDER));
        check("glider.u1.gen_sat", 32'(gen1), 32'd15);
        check("glider.u1.running", 32'(gs1), 32'd2);
        repeat (2) tick_in(P_NONE);

        // stop beats pp
        tick_in(P_STOP | P_PP);
        check("stop_pp.u0.state", 32'(gs0), 32'd0);
        check("stop_pp.u1.state", 32'(gs1), 32'd0);
        check("stop_pp.u1.grid", 32'(grid1), 32'd0);
        check("stop_pp.u1.gen", 32'(gen1), 32'd0);
        check("stop_pp.u1.cursor", 32'(cur1), 32'd0);

        // Cursor wrap and simultaneous toggle/advance at the last cell
        tick_in(P_PRGM);
        repeat (25) tick_in(P_BTN0);
        check("cursor.wrap25", 32'(cur0), 32'd0);
        repeat (24) tick_in(P_BTN0);
        check("cursor.at24", 32'(cur0), 32'd24);
        tick_in(P_BTN0 | P_BTN1);
        check("cursor.both.cursor", 32'(cur0), 32'd0);
        check("cursor.both.grid", 32'(grid0), 32'h1000000);
        tick_in(P_STOP);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) tick_in(rand_pulse());

        repeat (2) tick_in(P_NONE);
        @(negedge clk);
        #1;
        check("scoreboard.drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
